// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared constants for the multicycle MIPS controller: state encodings,
// supported opcodes, and the encodings driven onto the ALU and PC muxes.
// Also provides a helper that tells whether an opcode is implemented.
package mips_ctrl_pkg;

  // Controller states; State_o exposes these values directly.
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;

  // Implemented opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation select.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  // PC source select.
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // True when the opcode has a defined execution path through the FSM.
  function automatic logic is_legal_op(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode
// Purely combinational translation of the controller state into datapath
// control strobes. Most outputs depend only on the state; the FETCH loads
// and the MEMWR write strobe are qualified by mem_ready so that each one
// fires once per memory access, however long the access stretches.
// Ports:
//   state       current controller state
//   mem_ready   memory completes its access this cycle
//   opcode      instruction opcode, used only to flag illegal opcodes
//   iord .. reg_write  datapath controls (see mips_mc_control)
//   illegal     unsupported opcode seen in DECODE
module mc_ctrl_decode
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic [STW-1:0] state,
  input  logic           mem_ready,
  input  logic [OPW-1:0] opcode,
  output logic           iord,
  output logic           mem_write,
  output logic           ir_write,
  output logic           pc_write,
  output logic           branch,
  output logic [1:0]     pc_src,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           illegal
);

  // Everything defaults to 0 so IDLE and unused encodings drive a quiet
  // datapath; each state only raises the strobes it needs.
  always_comb begin
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    pc_src     = PC_SRC_ALU;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_OP_ADD;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (state)
      STW'(S_FETCH): begin
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      STW'(S_DECODE): begin
        alu_src_b = SRC_B_IMM_SH2;
        illegal   = !is_legal_op(6'(opcode));
      end
      STW'(S_MEMADR): begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      STW'(S_MEMRD): iord = 1'b1;
      STW'(S_MEMWR): begin
        iord      = 1'b1;
        mem_write = mem_ready;
      end
      STW'(S_MEMWB): begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      STW'(S_EXEC): begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      STW'(S_ALUWB): begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      STW'(S_BRANCH): begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_SUB;
        branch    = 1'b1;
        pc_src    = PC_SRC_ALUOUT;
      end
      STW'(S_ADDIEX): begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      STW'(S_ADDIWB): reg_write = 1'b1;
      STW'(S_JUMP): begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control
// Multicycle MIPS main controller. Holds the state register and next-state
// logic; control strobes come from mc_ctrl_decode.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   Opcode_i          opcode from the instruction register
//   Mem_Ready_i       memory finishes the current access this cycle
//   IorD_o .. Reg_Write_o  datapath mux selects and write strobes
//   Illegal_o         one-cycle flag for an unsupported opcode
//   State_o           current state for debug
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Opcode_i,
  input  logic           Mem_Ready_i,
  output logic           IorD_o,
  output logic           Mem_Write_o,
  output logic           IR_Write_o,
  output logic           PC_Write_o,
  output logic           Branch_o,
  output logic [1:0]     PC_Src_o,
  output logic           ALU_Src_A_o,
  output logic [1:0]     ALU_Src_B_o,
  output logic [1:0]     ALU_Op_o,
  output logic           Reg_Dst_o,
  output logic           Mem_to_Reg_o,
  output logic           Reg_Write_o,
  output logic           Illegal_o,
  output logic [STW-1:0] State_o
);

  logic [STW-1:0] state_q;
  logic [STW-1:0] state_d;
  logic [5:0]     op;

  assign op = 6'(Opcode_i);

  // Reset wins over everything, so an in-flight instruction is dropped
  // immediately, even while a memory access is being stretched.
  always_ff @(posedge clk) begin
    if (reset) state_q <= STW'(S_IDLE);
    else       state_q <= state_d;
  end

  // Next-state logic. Memory states hold until ready; the opcode is only
  // looked at in DECODE and MEMADR. Unused encodings fall back to IDLE.
  always_comb begin
    state_d = STW'(S_IDLE);
    case (state_q)
      STW'(S_IDLE):   state_d = STW'(S_FETCH);
      STW'(S_FETCH):  state_d = Mem_Ready_i ? STW'(S_DECODE) : STW'(S_FETCH);
      STW'(S_DECODE): begin
        case (op)
          OP_LW, OP_SW: state_d = STW'(S_MEMADR);
          OP_RTYPE:     state_d = STW'(S_EXEC);
          OP_BEQ:       state_d = STW'(S_BRANCH);
          OP_ADDI:      state_d = STW'(S_ADDIEX);
          OP_J:         state_d = STW'(S_JUMP);
          default:      state_d = STW'(S_FETCH);
        endcase
      end
      STW'(S_MEMADR): state_d = (op == OP_LW) ? STW'(S_MEMRD) : STW'(S_MEMWR);
      STW'(S_MEMRD):  state_d = Mem_Ready_i ? STW'(S_MEMWB) : STW'(S_MEMRD);
      STW'(S_MEMWR):  state_d = Mem_Ready_i ? STW'(S_FETCH) : STW'(S_MEMWR);
      STW'(S_EXEC):   state_d = STW'(S_ALUWB);
      STW'(S_ADDIEX): state_d = STW'(S_ADDIWB);
      STW'(S_MEMWB), STW'(S_ALUWB), STW'(S_ADDIWB),
      STW'(S_BRANCH), STW'(S_JUMP): state_d = STW'(S_FETCH);
      default:        state_d = STW'(S_IDLE);
    endcase
  end

  assign State_o = state_q;

  mc_ctrl_decode #(.OPW(OPW), .STW(STW)) u_decode (
    .state      (state_q),
    .mem_ready  (Mem_Ready_i),
    .opcode     (Opcode_i),
    .iord       (IorD_o),
    .mem_write  (Mem_Write_o),
    .ir_write   (IR_Write_o),
    .pc_write   (PC_Write_o),
    .branch     (Branch_o),
    .pc_src     (PC_Src_o),
    .alu_src_a  (ALU_Src_A_o),
    .alu_src_b  (ALU_Src_B_o),
    .alu_op     (ALU_Op_o),
    .reg_dst    (Reg_Dst_o),
    .mem_to_reg (Mem_to_Reg_o),
    .reg_write  (Reg_Write_o),
    .illegal    (Illegal_o)
  );

endmodule

// File: tb/tb_mips_mc_control.sv
// tb_mips_mc_control
// Self-checking bench for mips_mc_control. Each instruction is expanded into
// the list of cycles it should occupy (with chosen memory waits), and every
// cycle's state and control vector is compared against a per-state table.
module tb_mips_mc_control;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DECODE = 4'd2,
                         ST_MEMADR = 4'd3, ST_MEMRD = 4'd4, ST_MEMWB = 4'd5,
                         ST_MEMWR = 4'd6, ST_EXEC = 4'd7, ST_ALUWB = 4'd8,
                         ST_BRANCH = 4'd9, ST_ADDIEX = 4'd10, ST_ADDIWB = 4'd11,
                         ST_JUMP = 4'd12;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RTYPE = 6'h00,
                         BEQ = 6'h04, ADDI = 6'h08, JMP = 6'h02;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode_i;
  logic       Mem_Ready_i;
  logic       IorD_o, Mem_Write_o, IR_Write_o, PC_Write_o, Branch_o;
  logic [1:0] PC_Src_o, ALU_Src_B_o, ALU_Op_o;
  logic       ALU_Src_A_o, Reg_Dst_o, Mem_to_Reg_o, Reg_Write_o, Illegal_o;
  logic [3:0] State_o;

  ctrl_t      obs;
  ctrl_t      spec_tab [16];
  int         compare_count = 0;
  int         mismatch_count = 0;
  int         reg_write_seen;
  int         mem_write_seen;

  always #5 clk = ~clk;

  mips_mc_control #(.OPW(6), .STW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .Opcode_i     (Opcode_i),
    .Mem_Ready_i  (Mem_Ready_i),
    .IorD_o       (IorD_o),
    .Mem_Write_o  (Mem_Write_o),
    .IR_Write_o   (IR_Write_o),
    .PC_Write_o   (PC_Write_o),
    .Branch_o     (Branch_o),
    .PC_Src_o     (PC_Src_o),
    .ALU_Src_A_o  (ALU_Src_A_o),
    .ALU_Src_B_o  (ALU_Src_B_o),
    .ALU_Op_o     (ALU_Op_o),
    .Reg_Dst_o    (Reg_Dst_o),
    .Mem_to_Reg_o (Mem_to_Reg_o),
    .Reg_Write_o  (Reg_Write_o),
    .Illegal_o    (Illegal_o),
    .State_o      (State_o)
  );

  assign obs = {IorD_o, Mem_Write_o, IR_Write_o, PC_Write_o, Branch_o, PC_Src_o,
                ALU_Src_A_o, ALU_Src_B_o, ALU_Op_o, Reg_Dst_o, Mem_to_Reg_o,
                Reg_Write_o, Illegal_o};

  function automatic logic op_is_legal(input logic [5:0] op);
    return (op == LW) || (op == SW) || (op == RTYPE) ||
           (op == BEQ) || (op == ADDI) || (op == JMP);
  endfunction

  function automatic logic op_writes_reg(input logic [5:0] op);
    return (op == LW) || (op == RTYPE) || (op == ADDI);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // One cycle: drive inputs just after the edge, check mid-cycle.
  task automatic applyStimulus(input logic [3:0] st, input logic rdy,
                               input logic [5:0] op, input string tag);
    ctrl_t exp;
    Mem_Ready_i = rdy;
    Opcode_i    = op;
    @(negedge clk);
    exp = spec_tab[st];
    if (st == ST_FETCH) begin
      exp.ir_write = rdy;
      exp.pc_write = rdy;
    end
    if (st == ST_MEMWR) exp.mem_write = rdy;
    if (st == ST_DECODE) exp.illegal = !op_is_legal(op);
    checkOutput({tag, "_state"}, 32'(State_o), 32'(st));
    checkOutput({tag, "_ctrl"}, 32'(obs), 32'(exp));
    if (Reg_Write_o) reg_write_seen++;
    if (Mem_Write_o) mem_write_seen++;
    @(posedge clk);
    #1;
  endtask

  // Expands an instruction into its expected cycles, runs them, and checks
  // the number of register/memory write pulses. abort_at >= 0 pulses reset
  // during that cycle and expects the instruction to be dropped.
  task automatic runInstr(input logic [5:0] op, input int fetch_wait,
                          input int mem_wait, input int abort_at,
                          input string tag);
    step_t plan[$];
    bit    aborted = 0;
    for (int i = 0; i < fetch_wait; i++) plan.push_back('{ST_FETCH, 1'b0});
    plan.push_back('{ST_FETCH, 1'b1});
    plan.push_back('{ST_DECODE, 1'($urandom)});
    case (op)
      LW: begin
        plan.push_back('{ST_MEMADR, 1'($urandom)});
        for (int i = 0; i < mem_wait; i++) plan.push_back('{ST_MEMRD, 1'b0});
        plan.push_back('{ST_MEMRD, 1'b1});
        plan.push_back('{ST_MEMWB, 1'($urandom)});
      end
      SW: begin
        plan.push_back('{ST_MEMADR, 1'($urandom)});
        for (int i = 0; i < mem_wait; i++) plan.push_back('{ST_MEMWR, 1'b0});
        plan.push_back('{ST_MEMWR, 1'b1});
      end
      RTYPE: begin
        plan.push_back('{ST_EXEC, 1'($urandom)});
        plan.push_back('{ST_ALUWB, 1'($urandom)});
      end
      ADDI: begin
        plan.push_back('{ST_ADDIEX, 1'($urandom)});
        plan.push_back('{ST_ADDIWB, 1'($urandom)});
      end
      BEQ: plan.push_back('{ST_BRANCH, 1'($urandom)});
      JMP: plan.push_back('{ST_JUMP, 1'($urandom)});
      default: ;
    endcase
    reg_write_seen = 0;
    mem_write_seen = 0;
    for (int i = 0; i < plan.size(); i++) begin
      // The opcode is don't-care while fetching, so scramble it there.
      logic [5:0] drive_op;
      drive_op = (plan[i].st == ST_FETCH) ? 6'($urandom) : op;
      if (i == abort_at) begin
        reset = 1'b1;
        applyStimulus(plan[i].st, plan[i].rdy, drive_op, tag);
        reset = 1'b0;
        applyStimulus(ST_IDLE, 1'($urandom), op, {tag, "_abort"});
        aborted = 1;
        break;
      end
      applyStimulus(plan[i].st, plan[i].rdy, drive_op, tag);
    end
    checkOutput({tag, "_regwr_cnt"}, 32'(reg_write_seen),
                32'(op_writes_reg(op) && !aborted));
    checkOutput({tag, "_memwr_cnt"}, 32'(mem_write_seen),
                32'((op == SW) && !aborted));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [5:0] rand_op;
    logic [5:0] legal_list [6];
    legal_list = '{LW, SW, RTYPE, BEQ, ADDI, JMP};

    for (int i = 0; i < 16; i++) spec_tab[i] = '0;
    spec_tab[ST_FETCH].src_b       = 2'b01;
    spec_tab[ST_DECODE].src_b      = 2'b11;
    spec_tab[ST_MEMADR].src_a      = 1'b1;
    spec_tab[ST_MEMADR].src_b      = 2'b10;
    spec_tab[ST_MEMRD].iord        = 1'b1;
    spec_tab[ST_MEMWR].iord        = 1'b1;
    spec_tab[ST_MEMWB].mem_to_reg  = 1'b1;
    spec_tab[ST_MEMWB].reg_write   = 1'b1;
    spec_tab[ST_EXEC].src_a        = 1'b1;
    spec_tab[ST_EXEC].alu_op       = 2'b10;
    spec_tab[ST_ALUWB].reg_dst     = 1'b1;
    spec_tab[ST_ALUWB].reg_write   = 1'b1;
    spec_tab[ST_BRANCH].src_a      = 1'b1;
    spec_tab[ST_BRANCH].alu_op     = 2'b01;
    spec_tab[ST_BRANCH].branch     = 1'b1;
    spec_tab[ST_BRANCH].pc_src     = 2'b01;
    spec_tab[ST_ADDIEX].src_a      = 1'b1;
    spec_tab[ST_ADDIEX].src_b      = 2'b10;
    spec_tab[ST_ADDIWB].reg_write  = 1'b1;
    spec_tab[ST_JUMP].pc_src       = 2'b10;
    spec_tab[ST_JUMP].pc_write     = 1'b1;

    reset       = 1'b1;
    Mem_Ready_i = 1'b0;
    Opcode_i    = 6'h00;
    @(posedge clk);
    #1;
    applyStimulus(ST_IDLE, 1'b1, LW, "reset0");
    applyStimulus(ST_IDLE, 1'b0, SW, "reset1");
    reset = 1'b0;
    applyStimulus(ST_IDLE, 1'b1, LW, "post_reset");

    runInstr(LW,    0, 0, -1, "lw");
    runInstr(SW,    0, 3, -1, "sw_wait");
    runInstr(RTYPE, 0, 0, -1, "rtype");
    runInstr(ADDI,  0, 0, -1, "addi");
    runInstr(BEQ,   0, 0, -1, "beq");
    runInstr(JMP,   0, 0, -1, "j");
    runInstr(6'h3F, 0, 0, -1, "illegal");
    runInstr(LW,    0, 2,  4, "lw_abort");
    runInstr(LW,    1, 1, -1, "lw_after_abort");

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 6) == 6) rand_op = 6'($urandom);
      else rand_op = legal_list[$urandom_range(0, 5)];
      runInstr(rand_op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
               -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compare_count, mismatch_count);
    $finish;
  end

endmodule
